// File: rtl/matrix_mac_pkg.sv
// Shared widths, scaling constants and state encoding for the math-box MAC datapath.
package matrix_mac_pkg;
  localparam int WORD_W    = 16;
  localparam int ACC_W     = 32;
  localparam int MDB_LSB   = 15;
  localparam int MUL_STEPS = 16;
  localparam int CNT_W     = $clog2(MUL_STEPS);

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } mac_state_t;
endpackage

// File: rtl/matrix_serial_multiplier.sv
// 16-step radix-2 shift-add signed multiplier; product is valid combinationally
// alongside the one-cycle done pulse on the final step.
module matrix_serial_multiplier
  import matrix_mac_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [WORD_W-1:0] d_i,
  input  logic [WORD_W-1:0] c_i,
  output logic              done_o,
  output logic [ACC_W-1:0]  product_o
);

  logic              active_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [WORD_W-1:0] d_q;
  logic [WORD_W-1:0] c_q;
  logic [ACC_W-1:0]  part_q;
  logic [ACC_W-1:0]  part_d;
  logic [ACC_W-1:0]  addend_s;
  logic              last_s;

  // Partial-product step; the multiplier's sign bit carries weight -2^15,
  // so the final step subtracts instead of adding.
  always_comb begin
    addend_s = {{(ACC_W-WORD_W){d_q[WORD_W-1]}}, d_q} << cnt_q;
    last_s   = (cnt_q == CNT_W'(MUL_STEPS-1));
    part_d   = part_q;
    if (c_q[cnt_q]) begin
      if (last_s) begin
        part_d = part_q - addend_s;
      end else begin
        part_d = part_q + addend_s;
      end
    end else begin
      part_d = part_q;
    end
    done_o    = active_q && last_s;
    product_o = part_d;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      active_q <= 1'b0;
      cnt_q    <= '0;
      d_q      <= '0;
      c_q      <= '0;
      part_q   <= '0;
    end else if (start_i) begin
      active_q <= 1'b1;
      cnt_q    <= '0;
      d_q      <= d_i;
      c_q      <= c_i;
      part_q   <= '0;
    end else if (active_q) begin
      part_q <= part_d;
      cnt_q  <= cnt_q + CNT_W'(1);
      if (last_s) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/matrix_mac_unit.sv
// Math-box execute stage: ACC += (A - B) * C via a serial multiplier, with
// registered Q15 write-back word and busy flag for the sequencer.
module matrix_mac_unit
  import matrix_mac_pkg::*;
(
  input  logic              clk_12,
  input  logic              reset,
  input  logic              LDA,
  input  logic              LDB,
  input  logic              LDC,
  input  logic              CLEARACC,
  input  logic              LAC,
  input  logic [WORD_W-1:0] MDB_IN,
  output logic [WORD_W-1:0] MDB_OUT,
  output logic              MACFLAG
);

  mac_state_t        state_q, state_d;
  logic [WORD_W-1:0] a_q, a_d;
  logic [WORD_W-1:0] b_q, b_d;
  logic [WORD_W-1:0] c_q, c_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic [WORD_W-1:0] mdb_out_q, mdb_out_d;
  logic              macflag_q, macflag_d;
  logic              start_s;
  logic [WORD_W-1:0] diff_s;
  logic [ACC_W-1:0]  acc_base_s;
  logic              mul_done_s;
  logic [ACC_W-1:0]  mul_prod_s;

  matrix_serial_multiplier u_mul (
    .clk_i    (clk_12),
    .rst_i    (reset),
    .start_i  (start_s),
    .d_i      (diff_s),
    .c_i      (c_d),
    .done_o   (mul_done_s),
    .product_o(mul_prod_s)
  );

  // Operand capture, accumulator priority (LAC > CLEARACC, then product add)
  // and next state; same-edge LDB/LDC values feed a starting multiply.
  always_comb begin
    start_s = LDA && (state_q == IDLE);
    a_d     = start_s ? MDB_IN : a_q;
    b_d     = LDB ? MDB_IN : b_q;
    c_d     = LDC ? MDB_IN : c_q;
    diff_s  = a_d - b_d;

    if (LAC) begin
      acc_base_s = {{(ACC_W-WORD_W){MDB_IN[WORD_W-1]}}, MDB_IN} << MDB_LSB;
    end else if (CLEARACC) begin
      acc_base_s = '0;
    end else begin
      acc_base_s = acc_q;
    end

    if (mul_done_s) begin
      acc_d = acc_base_s + mul_prod_s;
    end else begin
      acc_d = acc_base_s;
    end

    state_d = state_q;
    case (state_q)
      IDLE:    state_d = start_s ? BUSY : IDLE;
      BUSY:    state_d = mul_done_s ? IDLE : BUSY;
      default: state_d = IDLE;
    endcase

    mdb_out_d = acc_d[MDB_LSB+WORD_W-1:MDB_LSB];
    macflag_d = (state_d == IDLE);
  end

  always_ff @(posedge clk_12 or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      acc_q     <= '0;
      mdb_out_q <= '0;
      macflag_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
      acc_q     <= acc_d;
      mdb_out_q <= mdb_out_d;
      macflag_q <= macflag_d;
    end
  end

  assign MDB_OUT = mdb_out_q;
  assign MACFLAG = macflag_q;

endmodule

// File: tb/tb_matrix_mac_unit.sv
// Self-checking bench for matrix_mac_unit: directed scenarios plus random
// strobe traffic against a cycle-level arithmetic reference model.
module tb_matrix_mac_unit;

  logic        clk;
  logic        reset;
  logic        LDA, LDB, LDC, CLEARACC, LAC;
  logic [15:0] MDB_IN;
  logic [15:0] MDB_OUT;
  logic        MACFLAG;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  shortint m_a, m_b, m_c;
  int      m_acc, m_p, m_left;
  bit      m_busy;

  matrix_mac_unit dut (
    .clk_12  (clk),
    .reset   (reset),
    .LDA     (LDA),
    .LDB     (LDB),
    .LDC     (LDC),
    .CLEARACC(CLEARACC),
    .LAC     (LAC),
    .MDB_IN  (MDB_IN),
    .MDB_OUT (MDB_OUT),
    .MACFLAG (MACFLAG)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_a = 0; m_b = 0; m_c = 0;
    m_acc = 0; m_p = 0; m_left = 0; m_busy = 1'b0;
  endtask

  task automatic model_edge(input bit lda, ldb, ldc, clr, lac, input logic [15:0] din);
    shortint b_eff, c_eff, sdin, diff;
    bit      was_busy, done;
    sdin     = shortint'(din);
    b_eff    = ldb ? sdin : m_b;
    c_eff    = ldc ? sdin : m_c;
    was_busy = m_busy;
    done     = m_busy && (m_left == 1);
    if (lac)      m_acc = int'(sdin) * 32768;
    else if (clr) m_acc = 0;
    if (done) begin
      m_acc  = m_acc + m_p;
      m_busy = 1'b0;
    end else if (m_busy) begin
      m_left = m_left - 1;
    end
    if (lda && !was_busy) begin
      m_a    = sdin;
      diff   = sdin - b_eff;
      m_p    = int'(diff) * int'(c_eff);
      m_busy = 1'b1;
      m_left = 16;
    end
    if (ldb) m_b = sdin;
    if (ldc) m_c = sdin;
  endtask

  task automatic step(input bit lda, ldb, ldc, clr, lac, input logic [15:0] din);
    logic [31:0] acc_v;
    LDA = lda; LDB = ldb; LDC = ldc; CLEARACC = clr; LAC = lac; MDB_IN = din;
    @(posedge clk);
    model_edge(lda, ldb, ldc, clr, lac, din);
    #1;
    acc_v = m_acc;
    check("macflag", {31'd0, MACFLAG}, {31'd0, ~m_busy});
    check("mdb_out", {16'd0, MDB_OUT}, {16'd0, acc_v[30:15]});
    check("acc", dut.acc_q, acc_v);
    check("a_reg", {16'd0, dut.a_q}, {16'd0, m_a});
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  // load B, C then A, wait for completion and report how long MACFLAG stayed low
  task automatic mul(input logic [15:0] b, c, a, output int lowcnt);
    lowcnt = 0;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, b);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, c);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, a);
    if (!MACFLAG) lowcnt++;
    for (int g = 0; g < 40; g++) begin
      if (MACFLAG) break;
      idle();
      if (!MACFLAG) lowcnt++;
    end
  endtask

  initial begin
    int lc;
    reset = 1'b1;
    LDA = 1'b0; LDB = 1'b0; LDC = 1'b0; CLEARACC = 1'b0; LAC = 1'b0; MDB_IN = 16'h0000;
    model_reset();
    #12;
    check("rst_flag", {31'd0, MACFLAG}, 32'd1);
    check("rst_mdb", {16'd0, MDB_OUT}, 32'd0);
    check("rst_acc", dut.acc_q, 32'd0);
    reset = 1'b0;

    // positive product
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    mul(16'h0000, 16'h4000, 16'h2000, lc);
    check("pos_low", lc, 32'd16);
    check("pos_acc", dut.acc_q, 32'h0800_0000);
    check("pos_mdb", {16'd0, MDB_OUT}, 32'h0000_1000);

    // accumulate then clear
    mul(16'h0000, 16'h4000, 16'h2000, lc);
    check("acc2_mdb", {16'd0, MDB_OUT}, 32'h0000_2000);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("clr_mdb", {16'd0, MDB_OUT}, 32'h0000_0000);

    // signed difference
    mul(16'h3000, 16'h7FFF, 16'h1000, lc);
    check("neg_acc", dut.acc_q, 32'hF000_2000);
    check("neg_mdb", {16'd0, MDB_OUT}, 32'h0000_E000);

    // load accumulator
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    check("lac_acc", dut.acc_q, 32'h091A_0000);
    check("lac_mdb", {16'd0, MDB_OUT}, 32'h0000_1234);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 16'h8000);
    check("lac_neg", dut.acc_q, 32'hC000_0000);

    // LDA while busy is ignored
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'h4000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000);
    lc = 1;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h7777);
    if (!MACFLAG) lc++;
    for (int g = 0; g < 40; g++) begin
      if (MACFLAG) break;
      idle();
      if (!MACFLAG) lc++;
    end
    check("ldabusy_low", lc, 32'd16);
    check("ldabusy_a", {16'd0, dut.a_q}, 32'h0000_2000);
    check("ldabusy_acc", dut.acc_q, 32'h0800_0000);

    // CLEARACC on the completion edge
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000);
    for (int i = 0; i < 15; i++) idle();
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check("clr_done_acc", dut.acc_q, 32'h0800_0000);
    check("clr_done_flag", {31'd0, MACFLAG}, 32'd1);

    // same-edge LDB / LDC feed the starting multiply
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h1000);
    step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'h3000);
    for (int i = 0; i < 16; i++) idle();
    check("ldb_same_acc", dut.acc_q, 32'h0000_0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 16'h2000);
    for (int i = 0; i < 16; i++) idle();
    check("ldc_same_acc", dut.acc_q, 32'h0400_0000);

    // asynchronous reset mid-multiply
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'h1234);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h2000);
    for (int i = 0; i < 5; i++) idle();
    #2 reset = 1'b1;
    #1;
    check("arst_flag", {31'd0, MACFLAG}, 32'd1);
    check("arst_mdb", {16'd0, MDB_OUT}, 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
    for (int i = 0; i < 20; i++) idle();
    check("arst_noadd", dut.acc_q, 32'd0);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(7) == 0), ($urandom_range(5) == 0), ($urandom_range(5) == 0),
           ($urandom_range(19) == 0), ($urandom_range(19) == 0), 16'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
